// File: rtl/demux_capture.sv
// demux_capture: per-channel rising-edge counters on the demux output bus, with one-hot check and a one-cycle read port.
module demux_capture #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:7]    f,
    input  logic          clr,
    input  logic          rd_req,
    input  logic [0:2]    rd_sel,
    input  logic          rd_clr,
    output logic          rd_ack,
    output logic [CW-1:0] rd_data,
    output logic          rd_ovf,
    output logic [0:2]    last_ch,
    output logic          last_vld,
    output logic          multi_err
);
    localparam logic [CW-1:0] MAX = '1;

    logic [0:7]    f_q, rise, wipe;
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];
    logic [0:7]    ovf_q, ovf_d;
    logic [0:2]    last_ch_q, last_ch_d;
    logic          last_vld_q, last_vld_d, multi_err_q, multi_err_d;
    logic          rd_ack_q, rd_ovf_q, rd_ovf_d;
    logic [CW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rise        = f & ~f_q;
        wipe        = '0;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        last_ch_d   = last_ch_q;
        last_vld_d  = last_vld_q | (|rise);
        multi_err_d = multi_err_q | ($countones(f) > 1);
        // descending scan leaves the lowest-index rising channel
        for (int k = 7; k >= 0; k--)
            if (rise[k]) last_ch_d = 3'(k);
        for (int k = 0; k < 8; k++) begin
            wipe[k]  = rd_req && rd_clr && (rd_sel == 3'(k));
            cnt_d[k] = wipe[k] ? '0 : cnt_q[k];
            ovf_d[k] = wipe[k] ? 1'b0 : ovf_q[k];
            if (rise[k]) begin
                if (cnt_d[k] == MAX) ovf_d[k] = 1'b1;
                else cnt_d[k] = cnt_d[k] + 1'b1;
            end
        end
        if (clr) begin
            cnt_d       = '{default: '0};
            ovf_d       = '0;
            last_ch_d   = '0;
            last_vld_d  = 1'b0;
            multi_err_d = 1'b0;
        end
        rd_data_d = rd_req ? cnt_q[rd_sel] : rd_data_q;
        rd_ovf_d  = rd_req ? ovf_q[rd_sel] : rd_ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= '0;
            cnt_q       <= '{default: '0};
            ovf_q       <= '0;
            last_ch_q   <= '0;
            last_vld_q  <= 1'b0;
            multi_err_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_ovf_q    <= 1'b0;
        end else begin
            f_q         <= f;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            last_ch_q   <= last_ch_d;
            last_vld_q  <= last_vld_d;
            multi_err_q <= multi_err_d;
            rd_ack_q    <= rd_req;
            rd_data_q   <= rd_data_d;
            rd_ovf_q    <= rd_ovf_d;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign rd_ovf    = rd_ovf_q;
    assign last_ch   = last_ch_q;
    assign last_vld  = last_vld_q;
    assign multi_err = multi_err_q;
endmodule

// File: doc/demux_capture.md
# demux_capture

Per-channel event capture stage that sits directly downstream of the 1x8 demultiplexer and consumes its 8-bit output bus `f[0:7]`. It detects rising edges on each demux channel and accumulates them in saturating counters. It flags one-hot violations and records the most recently active channel. Counts are read out via a single-request/single-acknowledge port with fixed one-cycle latency and optional read-and-clear.

## Interface
Parameters:
- `CW`, 8, width of each per-channel event counter (legal 2..16).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `f`  in  [0:7]  demux output bus; `f[k]` is channel k. Synchronous to `clk`.
- `clr`  in  1  synchronous clear of all counters, overflow flags, `multi_err`, `last_ch`, `last_vld`.
- `rd_req`  in  1  read request, one cycle wide; accepted every cycle it is high.
- `rd_sel`  in  [0:2]  channel to read; `rd_sel = 3'b000` selects channel 0.
- `rd_clr`  in  1  with `rd_req`: clear the selected counter and overflow flag after reading.
- `rd_ack`  out  1  read data valid; high exactly one cycle after each accepted `rd_req`.
- `rd_data`  out  CW  counter value of the selected channel.
- `rd_ovf`  out  1  sticky overflow flag of the selected channel.
- `last_ch`  out  [0:2]  index of the most recent channel with a rising edge.
- `last_vld`  out  1  `last_ch` holds a valid index.
- `multi_err`  out  1  sticky flag: more than one bit of `f` was high in a sampled cycle.

## Operation
- Previous-sample register `f_q[0:7]` captures `f` each cycle. Rising edge: `rise[k] = f[k] & ~f_q[k]`.
- Counter k increments by 1 on `rise[k]`.
  - At `2^CW-1` the counter holds its value and `ovf[k]` sets.
  - `ovf[k]` stays set until a clear.
- Several channels may rise in the same cycle. Each counter updates independently.
- `last_ch`/`last_vld`:
  - On any rise, `last_ch` takes the lowest-index rising channel and `last_vld` goes to 1.
  - With no rise, both hold.
- `multi_err` sets when the popcount of `f` in a cycle is ≥2. It is sticky.
- Read:
  - In the request cycle, `rd_data`/`rd_ovf` load the selected counter and flag values before that cycle's update, then register.
  - `rd_ack` is high for one cycle.
  - Back-to-back requests on consecutive cycles give back-to-back acks.
- `rd_clr` with `rd_req`: the selected counter is set to 0 and its overflow flag to 0 at that edge. A rise on the same channel in the same cycle makes the new count 1.
- `clr` priority:
  - `clr` beats rise, `rd_clr`, and sticky sets. After a `clr` edge all counters, `ovf`, `multi_err`, `last_vld` and `last_ch` are 0, and rises in that cycle are discarded.
  - `f_q` still samples, so a level held across `clr` does not re-count.
  - A `rd_req` in the `clr` cycle returns pre-clear values.
- `rd_data`/`rd_ovf` hold their last values when `rd_ack` is low.

## Timing
- Reset (`rst_n` low, asynchronous): `f_q`, all counters, all `ovf`, `rd_ack`, `rd_data`, `rd_ovf`, `last_ch`, `last_vld` and `multi_err` are 0 immediately.
- A reset asserted mid-read suppresses the pending `rd_ack`.
- Edge latency: a rise of `f[k]` sampled at edge N is visible in the counter after edge N. A read requested at edge N+1 returns it.
- Read latency: `rd_req` sampled at edge N gives `rd_ack`=1 and valid data after edge N and before edge N+1.
- A channel held high for many cycles counts once. A 0→1→0→1 pattern on consecutive cycles counts twice.
- The first cycle after reset release treats `f_q` as 0. A channel already high at release counts once.

## Test plan
- Reset, then `f` steps through one-hot 10000000, 01000000 … 00000001, one cycle each with a zero cycle between. Read each channel → every `rd_data`=1, `last_ch`=7, `multi_err`=0.
- `CW`=4: 17 pulses on channel 3. Read → `rd_data`=15, `rd_ovf`=1. Read with `rd_clr` → next read gives 0/0.
- `f`=00100100 for one cycle → counters 2 and 5 = 1, `last_ch`=2, `multi_err`=1 and still 1 after 10 idle cycles.
- Channel 6 high for 20 cycles → count 1. Assert `clr` mid-hold → all 0, and no recount while held.
- `rd_req` with `rd_sel`=1 and `rd_clr`=1 in the same cycle as a rise on channel 1 (prior count 4) → `rd_data`=4, then a subsequent read gives 1.
- Four consecutive `rd_req` (sel 0,1,2,3) → four consecutive `rd_ack` cycles with matching data. `rst_n` low in the third request cycle → no further acks, all outputs 0.
